// File: rtl/hsi_pkg.sv
// hsi_pkg: shared HSI line constants and encoder state type
package hsi_pkg;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam logic LSB = 1'b0;
  localparam logic MSB = 1'b1;
  localparam int TICKS_PER_BIT_DEF = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} hsi_state_e;
endpackage

// File: rtl/hsi_tick_counter.sv
// hsi_tick_counter: modulo-TICKS clk_en counter with end-of-bit strobe
module hsi_tick_counter #(
  parameter int TICKS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic clk_en,
  output logic bit_end
);
  localparam int W = TICKS > 1 ? $clog2(TICKS) : 1;
  logic [W-1:0] cnt;
  assign bit_end = clk_en && cnt == W'(TICKS - 1);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (clk_en) cnt <= bit_end ? '0 : cnt + W'(1);
endmodule

// File: rtl/hsi_encoder.sv
// hsi_encoder: double-buffered byte-to-serial HSI frame transmitter
module hsi_encoder
  import hsi_pkg::*;
#(
  parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF,
  parameter int GAP_BITS = 2,
  parameter logic ML_FST = LSB
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] d,
  input  logic       d_valid,
  input  logic       d_last,
  output logic       d_ready,
  output logic       q,
  output logic       busy,
  output logic       frame_sent
);
  localparam int GW = $clog2(GAP_BITS + 1);
  hsi_state_e state, state_n;
  logic [7:0] hold_d, sh, sh_n;
  logic hold_last, full, live, accept, load, bit_end;
  logic par, par_n, last, last_n, cur, q_n;
  logic [2:0] bit_cnt, bit_n;
  logic [GW-1:0] gap_cnt, gap_n;
  hsi_tick_counter #(.TICKS(TICKS_PER_BIT)) u_tick (
    .clk(clk), .rst(rst), .clr(state == IDLE), .clk_en(clk_en), .bit_end(bit_end)
  );
  // live keeps d_ready low for the cycle that follows a reset edge
  assign d_ready = live && !full;
  assign accept = d_valid && d_ready;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    sh_n = sh;
    par_n = par;
    last_n = last;
    bit_n = bit_cnt;
    gap_n = gap_cnt;
    load = 1'b0;
    case (state)
      IDLE: if (clk_en && full) begin
        state_n = START;
        load = 1'b1;
      end
      START: if (bit_end) begin
        state_n = DATA;
        bit_n = '0;
      end
      DATA: if (bit_end) begin
        sh_n = ML_FST == LSB ? sh >> 1 : sh << 1;
        bit_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_n = PARITY;
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP: if (bit_end) begin
        if (last) begin
          state_n = GAP;
          gap_n = '0;
        end else if (full) begin
          state_n = START;
          load = 1'b1;
        end else state_n = IDLE;
      end
      GAP: if (bit_end) begin
        gap_n = gap_cnt + GW'(1);
        if (gap_cnt == GW'(GAP_BITS - 1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      sh_n = hold_d;
      par_n = ~^hold_d;
      last_n = hold_last;
    end
    cur = ML_FST == LSB ? sh_n[0] : sh_n[7];
    q_n = state_n == START ? START_BIT : state_n == DATA ? cur : state_n == PARITY ? par_n : STOP_BIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q <= STOP_BIT;
      full <= 1'b0;
      live <= 1'b0;
      frame_sent <= 1'b0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      last <= 1'b0;
      hold_d <= '0;
      hold_last <= 1'b0;
    end else begin
      live <= 1'b1;
      full <= load ? 1'b0 : accept ? 1'b1 : full;
      if (accept) begin
        hold_d <= d;
        hold_last <= d_last;
      end
      frame_sent <= state == STOP && bit_end;
      state <= state_n;
      sh <= sh_n;
      par <= par_n;
      last <= last_n;
      bit_cnt <= bit_n;
      gap_cnt <= gap_n;
      q <= q_n;
    end
  end
endmodule

// File: tb/tb_hsi_encoder.sv
// tb_hsi_encoder: directed frame checks for LSB- and MSB-first encoders
module tb_hsi_encoder;
  import hsi_pkg::*;
  logic clk = 0, rst = 1, clk_en = 1, d_valid = 0, d_last = 0;
  logic [7:0] d = '0;
  logic d_ready, q_l, busy, frame_sent, d_ready_m, q_m, busy_m, fs_m;
  int errs = 0, checks = 0, fs_cnt = 0, n;
  always #5 clk = ~clk;
  hsi_encoder #(.TICKS_PER_BIT(8), .GAP_BITS(2), .ML_FST(LSB)) dut_l (
    .clk(clk), .rst(rst), .clk_en(clk_en), .d(d), .d_valid(d_valid), .d_last(d_last),
    .d_ready(d_ready), .q(q_l), .busy(busy), .frame_sent(frame_sent)
  );
  hsi_encoder #(.TICKS_PER_BIT(8), .GAP_BITS(2), .ML_FST(MSB)) dut_m (
    .clk(clk), .rst(rst), .clk_en(clk_en), .d(d), .d_valid(d_valid), .d_last(d_last),
    .d_ready(d_ready_m), .q(q_m), .busy(busy_m), .frame_sent(fs_m)
  );
  always @(negedge clk) if (frame_sent) fs_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b, input logic l);
    int w = 0;
    while (!d_ready && w < 300) begin
      step();
      w++;
    end
    chk("send_ready", d_ready, 1);
    d = b;
    d_last = l;
    d_valid = 1;
    step();
    d_valid = 0;
  endtask
  // expects to be called on tick 0 of a frame; bit k of the line is sampled mid-bit
  task automatic check_frame(input string tag, input logic [10:0] exp, input logic use_m);
    for (int k = 0; k < 11; k++) begin
      step(4);
      d_valid = 0;
      chk($sformatf("%s_b%0d", tag, k), use_m ? q_m : q_l, exp[10-k]);
      step(4);
    end
    chk({tag, "_sent"}, frame_sent, 1);
  endtask
  task automatic wait_start(output int c);
    c = 0;
    while (q_l !== 1'b0 && c < 300) begin
      step();
      c++;
    end
    chk("start_seen", q_l, 0);
  endtask
  initial begin
    step(3);
    chk("rst_q", q_l, 1);
    chk("rst_ready", d_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sent", frame_sent, 0);
    rst = 0;
    step();
    chk("ready_after_rst", d_ready, 1);
    send(8'hA5, 1);
    chk("hold_full", d_ready, 0);
    step();
    check_frame("a5", 11'b01010010111, 0);
    chk("a5_gap_busy", busy, 1);
    step();
    chk("a5_sent_pulse", frame_sent, 0);
    step(14);
    chk("gap_busy_end", busy, 1);
    step();
    chk("gap_idle", busy, 0);
    send(8'h01, 0);
    step();
    check_frame("msb01", 11'b00000000101, 1);
    chk("msb01_no_gap", busy_m, 0);
    send(8'h3C, 0);
    step();
    d = 8'hC3;
    d_last = 1;
    d_valid = 1;
    check_frame("b2b_3c", 11'b00011110011, 0);
    chk("b2b_busy", busy, 1);
    check_frame("b2b_c3", 11'b01100001111, 0);
    send(8'h5A, 1);
    wait_start(n);
    chk("gap_then_start", n, 16);
    send(8'h81, 1);
    d = 8'h7E;
    d_last = 0;
    d_valid = 1;
    step(3);
    chk("no_accept_full", d_ready, 0);
    d_valid = 0;
    step(26);
    clk_en = 0;
    step(20);
    chk("freeze_q", q_l, 0);
    chk("freeze_busy", busy, 1);
    clk_en = 1;
    step();
    chk("resume_q_hold", q_l, 0);
    step();
    chk("resume_next_bit", q_l, 1);
    step(55);
    chk("late_not_sent", frame_sent, 0);
    step();
    chk("late_sent", frame_sent, 1);
    wait_start(n);
    chk("queued_start", n, 17);
    check_frame("held81", 11'b01000000111, 0);
    step();
    chk("frames_done", fs_cnt, 6);
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk("idle_before_rst", busy, 0);
    send(8'h69, 0);
    step();
    send(8'h55, 1);
    step(38);
    rst = 1;
    step();
    chk("midrst_q", q_l, 1);
    chk("midrst_ready", d_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sent", frame_sent, 0);
    rst = 0;
    step();
    chk("postrst_ready", d_ready, 1);
    step(150);
    chk("discard_busy", busy, 0);
    chk("discard_q", q_l, 1);
    chk("no_abort_pulse", fs_cnt, 6);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hsi_encoder.md
HSI_ENCODER -- requirements
Module: hsi_encoder

Interface
REQ-001 Parameter TICKS_PER_BIT, default 8, number of clk_en ticks per line bit.
REQ-002 Parameter GAP_BITS, default 2, number of idle-high bit periods after a message's last frame.
REQ-003 Parameter ML_FST, default LSB (shared constant), data bit order on the line.
REQ-004 Port clk, input, 1, the single clock; every register is clocked on its rising edge.
REQ-005 Port rst, input, 1, reset; synchronous, active-high.
REQ-006 Port clk_en, input, 1, line tick enable; every line-timing counter advances only on cycles where it is high.
REQ-007 Port d, input, 8, byte to transmit.
REQ-008 Port d_valid, input, 1, d and d_last are valid.
REQ-009 Port d_last, input, 1, the byte is the final frame of a message.
REQ-010 Port d_ready, output, 1, the holding register is empty and can accept a byte.
REQ-011 Port q, output, 1, serial line; idle level is 1 (STOP_BIT).
REQ-012 Port busy, output, 1, a frame or gap is in progress (state not IDLE).
REQ-013 Port frame_sent, output, 1, one-cycle pulse when the stop bit of a frame completes.

Function
REQ-014 Frame format: start bit 0, eight data bits, parity bit, stop bit 1; 11 bits total, TICKS_PER_BIT clk_en ticks each (88 ticks at the default).
REQ-015 Data order: ML_FST=LSB sends d[0] first; ML_FST=MSB sends d[7] first; parity always follows the data bits.
REQ-016 Parity bit equals NOT(XOR of d[7:0]) (odd parity over data plus parity).
REQ-017 Handshake: a byte is accepted on any clk edge with d_valid & d_ready, regardless of clk_en; d and d_last are latched into the holding register.
REQ-018 d_ready equals NOT(holding register full); the holding register frees when its contents move into the shift register, which allows double buffering during a frame.
REQ-019 States: IDLE, START, DATA, PARITY, STOP, GAP; q is registered and equals 0 in START, the current bit in DATA/PARITY, and 1 in STOP/GAP/IDLE.
REQ-020 IDLE->START on a clk_en cycle with the holding register full; the shift register, parity, and last flag load on that cycle; q goes to 0 on the following cycle.
REQ-021 Each of START, PARITY, and STOP lasts exactly TICKS_PER_BIT clk_en ticks; DATA lasts 8*TICKS_PER_BIT, with a 3-bit bit counter advancing every TICKS_PER_BIT ticks.
REQ-022 At the end of STOP, frame_sent pulses for one cycle. If the frame was last -> GAP. Else if the holding register is full -> START on that same tick, giving back-to-back frames with no extra idle. Else -> IDLE.
REQ-023 GAP holds q=1 for GAP_BITS*TICKS_PER_BIT ticks, then -> IDLE; bytes may be accepted into the holding register during GAP.
REQ-024 clk_en low freezes state, counters, and q; the handshake stays live.
REQ-025 d_valid with d_ready low: no acceptance; the holding register is unchanged; the upstream block holds its data.

Reset
REQ-026 While rst is high at a clk edge: state=IDLE, q=1, holding register empty, d_ready=0, busy=0, frame_sent=0, all counters 0; d_ready=1 from the first cycle after rst deasserts.
REQ-027 Reset mid-frame aborts the frame; q returns to 1 on the same edge; buffered bytes are discarded.

Structure
REQ-028 START_BIT, STOP_BIT, LSB/MSB, and the default TICKS_PER_BIT belong in the shared HSI configuration package; they are common with the decoder.
REQ-029 One sub-module, hsi_tick_counter: the modulo-TICKS_PER_BIT clk_en counter with an end-of-bit strobe.

Verification
REQ-030 LSB, d=0xA5, last=1 -> q held 8 ticks each: 0,1,0,1,0,0,1,0,1,1(parity),1(stop); frame_sent pulses at tick 88; busy=1 until tick 104.
REQ-031 MSB, d=0x01 -> q: 0, 0,0,0,0,0,0,0,1, 0(parity), 1.
REQ-032 Two bytes 0x3C (last=0) then 0xC3 (last=1) offered back-to-back -> the second start bit begins at tick 88; the second byte is accepted while the first is shifting.
REQ-033 Frame with last=1 followed immediately by a new byte -> the next start bit begins no earlier than tick 104.
REQ-034 clk_en held low 20 cycles mid-DATA -> q and the bit position are unchanged; the frame finishes 20 cycles later.
REQ-035 rst asserted at tick 40 of a frame -> q=1, d_ready=0 that cycle and 1 the next, busy=0, and no frame_sent pulse.
